// File: rtl/count_pulse_gen_pkg.sv
// count_pulse_pkg: shared debounce state encoding and operating-mode constants.
// No ports; imported by count_pulse_gen.
package count_pulse_pkg;
  typedef enum logic [1:0] {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW} deb_state_t;
  localparam logic MODE_EVENT    = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/count_pulse_gen_if.sv
// count_pulse_gen_if: event/periodic enable generator bus.
// Signals: event_in (raw async level), mode (0 event, 1 periodic), prescale (period-1),
// count_enable (single-cycle strobe), event_level (debounced level).
// master drives the inputs and observes the outputs; slave is the generator side.
interface count_pulse_gen_if #(parameter int PRESCALE_WIDTH = 8);
  logic                      event_in;
  logic                      mode;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      count_enable;
  logic                      event_level;
  modport master (output event_in, mode, prescale, input count_enable, event_level);
  modport slave  (input event_in, mode, prescale, output count_enable, event_level);
endinterface

// File: rtl/count_pulse_gen_sync.sv
// bit_synchronizer: two-flop synchronizer for a single asynchronous bit, reset value 0.
// Ports: i_clock (clock), i_reset_n (async active-low reset), i_d (async input), o_q (synchronized output).
module bit_synchronizer (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_sync;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end
  assign o_q = r_sync;
endmodule

// File: rtl/count_pulse_gen.sv
// count_pulse_gen: count_enable strobe generator (debounced event edges or programmable prescaler).
// Ports: i_clock (clock), i_reset_n (async active-low reset),
// bus (count_pulse_gen_if.slave: event_in, mode, prescale in; count_enable, event_level out).
module count_pulse_gen
  import count_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRESCALE_WIDTH  = 8
) (
  input logic              i_clock,
  input logic              i_reset_n,
  count_pulse_gen_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  deb_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_sat;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic r_level, w_level_nxt, r_level_d, r_mode, r_mode_vld, r_ce;
  logic w_sync, w_cnt_done, w_mode_chg, w_wrap;
  bit_synchronizer u_sync (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_d      (bus.event_in),
    .o_q      (w_sync)
  );
  assign w_cnt_sat  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
  assign w_cnt_done = (w_cnt_sat == CNT_MAX);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    case (r_state)
      STABLE_LOW: begin
        w_state_nxt = w_sync ? CHECK_HIGH : STABLE_LOW;
        w_cnt_nxt   = w_sync ? '0 : r_cnt;
      end
      CHECK_HIGH: begin
        w_state_nxt = !w_sync ? STABLE_LOW : (w_cnt_done ? STABLE_HIGH : CHECK_HIGH);
        w_cnt_nxt   = w_sync ? w_cnt_sat : '0;
        w_level_nxt = w_sync && w_cnt_done;
      end
      STABLE_HIGH: begin
        w_state_nxt = !w_sync ? CHECK_LOW : STABLE_HIGH;
        w_cnt_nxt   = !w_sync ? '0 : r_cnt;
      end
      CHECK_LOW: begin
        w_state_nxt = w_sync ? STABLE_HIGH : (w_cnt_done ? STABLE_LOW : CHECK_LOW);
        w_cnt_nxt   = !w_sync ? w_cnt_sat : '0;
        w_level_nxt = !(!w_sync && w_cnt_done);
      end
      default: w_state_nxt = STABLE_LOW;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end
  // r_mode_vld keeps the first edge after reset from looking like a mode change,
  // so periodic counting starts on that edge.
  assign w_mode_chg = r_mode_vld && (bus.mode != r_mode);
  assign w_wrap     = (r_presc == bus.prescale);
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_level_d  <= 1'b0;
      r_mode     <= MODE_EVENT;
      r_mode_vld <= 1'b0;
      r_presc    <= '0;
      r_ce       <= 1'b0;
    end else begin
      r_level_d  <= r_level;
      r_mode     <= bus.mode;
      r_mode_vld <= 1'b1;
      r_presc    <= (w_mode_chg || bus.mode == MODE_EVENT || w_wrap) ? '0 : r_presc + PRESCALE_WIDTH'(1);
      r_ce       <= !w_mode_chg && ((bus.mode == MODE_PERIODIC) ? w_wrap : (r_level && !r_level_d));
    end
  end
  assign bus.count_enable = r_ce;
  assign bus.event_level  = r_level;
endmodule

// File: tb/tb_count_pulse_gen.sv
// tb_count_pulse_gen: directed and randomized checks of count_pulse_gen against a behavioural model.
module tb_count_pulse_gen;
  localparam int D  = 4;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  count_pulse_gen_if #(.PRESCALE_WIDTH(PW)) bus ();
  count_pulse_gen #(.DEBOUNCE_CYCLES(D), .PRESCALE_WIDTH(PW)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  // Model: the level flips once D+1 consecutive synchronized samples disagree with it;
  // event pulses follow level rises; periodic pulses land where the edge count since
  // the phase start hits prescale modulo prescale+1.
  logic [1:0] ev_q;
  int m_run, m_t;
  logic m_level, m_level_prev, m_mode_last, m_mode_vld, m_ce;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q <= 2'b00;
      m_run <= 0;
      m_t <= 0;
      m_level <= 1'b0;
      m_level_prev <= 1'b0;
      m_mode_last <= 1'b0;
      m_mode_vld <= 1'b0;
      m_ce <= 1'b0;
    end else begin
      ev_q <= {ev_q[0], bus.event_in};
      if (ev_q[1] != m_level) begin
        if (m_run == D) begin
          m_level <= ~m_level;
          m_run <= 0;
        end else m_run <= m_run + 1;
      end else m_run <= 0;
      m_level_prev <= m_level;
      m_mode_last <= bus.mode;
      m_mode_vld <= 1'b1;
      if (m_mode_vld && bus.mode != m_mode_last) begin
        m_t <= 0;
        m_ce <= 1'b0;
      end else if (bus.mode) begin
        m_ce <= (m_t % (int'(bus.prescale) + 1)) == int'(bus.prescale);
        m_t <= m_t + 1;
      end else begin
        m_ce <= m_level && !m_level_prev;
        m_t <= 0;
      end
    end
  end
  task automatic do_reset(input logic ev, input logic md, input logic [PW-1:0] ps);
    @(negedge clk);
    rst_n = 1'b0;
    bus.event_in = ev;
    bus.mode = md;
    bus.prescale = ps;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.event_in = 1'b1;
    bus.mode = 1'b0;
    bus.prescale = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.count_enable !== 1'b0 || bus.event_level !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d ce=%b lvl=%b required 0/0", k, bus.count_enable, bus.event_level);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (bus.count_enable !== (k == D + 3) || bus.event_level !== (k >= D + 2)) begin
        errors++;
        $display("FAIL reset_release edge%0d ce=%b lvl=%b required %b/%b", k, bus.count_enable,
                 bus.event_level, (k == D + 3), (k >= D + 2));
      end
    end
  endtask
  task automatic test_glitch();
    int pulses = 0;
    do_reset(1'b0, 1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (bus.count_enable !== 1'b0 || bus.event_level !== 1'b0) begin
        errors++;
        $display("FAIL glitch_short cyc%0d ce=%b lvl=%b required 0/0", k, bus.count_enable, bus.event_level);
      end
      bus.event_in = (k < 3);
    end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      pulses += int'(bus.count_enable);
      checks++;
      if (bus.count_enable !== m_ce || bus.event_level !== m_level) begin
        errors++;
        $display("FAIL glitch_long cyc%0d ce=%b lvl=%b required %b/%b", k, bus.count_enable,
                 bus.event_level, m_ce, m_level);
      end
      bus.event_in = (k < 10);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL glitch_pulse_count got %0d required 1", pulses);
    end
  endtask
  task automatic test_bounce();
    logic rise_pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    int pulses = 0;
    do_reset(1'b0, 1'b0, '0);
    for (int k = 0; k < 24; k++) begin
      bus.event_in = (k < 10) ? rise_pat[k] : 1'b1;
      @(negedge clk);
      pulses += int'(bus.count_enable);
      checks++;
      if (bus.count_enable !== m_ce || bus.event_level !== m_level) begin
        errors++;
        $display("FAIL bounce_rise cyc%0d ce=%b lvl=%b required %b/%b", k, bus.count_enable,
                 bus.event_level, m_ce, m_level);
      end
    end
    checks++;
    if (pulses !== 1 || bus.event_level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_rise_total pulses=%0d lvl=%b required 1/1", pulses, bus.event_level);
    end
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      bus.event_in = (k < 10) ? ~rise_pat[k] : 1'b0;
      @(negedge clk);
      pulses += int'(bus.count_enable);
      checks++;
      if (bus.count_enable !== m_ce || bus.event_level !== m_level) begin
        errors++;
        $display("FAIL bounce_fall cyc%0d ce=%b lvl=%b required %b/%b", k, bus.count_enable,
                 bus.event_level, m_ce, m_level);
      end
    end
    checks++;
    if (pulses !== 0 || bus.event_level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_fall_total pulses=%0d lvl=%b required 0/0", pulses, bus.event_level);
    end
  endtask
  task automatic test_periodic();
    do_reset(1'b0, 1'b1, PW'(3));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (bus.count_enable !== (k % 4 == 3) || bus.count_enable !== m_ce) begin
        errors++;
        $display("FAIL periodic_p3 edge%0d ce=%b required %b", k, bus.count_enable, (k % 4 == 3));
      end
    end
    do_reset(1'b0, 1'b1, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.count_enable !== 1'b1) begin
        errors++;
        $display("FAIL periodic_p0 edge%0d ce=%b required 1", k, bus.count_enable);
      end
    end
  endtask
  task automatic test_mode_switch();
    logic exp;
    do_reset(1'b0, 1'b1, PW'(3));
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      exp = (k >= 8) && (k > 8) && ((k - 8) % 4 == 0);
      checks++;
      if (bus.count_enable !== exp || bus.count_enable !== m_ce) begin
        errors++;
        $display("FAIL mode_switch edge%0d ce=%b required %b", k, bus.count_enable, exp);
      end
      if (k == 1) bus.mode = 1'b0;
      if (k == 7) bus.mode = 1'b1;
    end
  endtask
  task automatic test_integration();
    logic [3:0] cnt4 = 4'd0;
    int carries = 0;
    int carry_at = -1;
    do_reset(1'b0, 1'b1, '0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.count_enable === 1'b1) begin
        if (cnt4 == 4'd15) begin
          carries++;
          carry_at = k;
        end
        cnt4 = cnt4 + 4'd1;
      end
    end
    checks++;
    if (cnt4 !== 4'd0 || carries !== 1 || carry_at !== 15) begin
      errors++;
      $display("FAIL integration cnt=%0d carries=%0d at=%0d required 0/1/15", cnt4, carries, carry_at);
    end
  endtask
  task automatic test_random();
    int run = 0;
    do_reset(1'b0, 1'b0, PW'(2));
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      checks++;
      if (bus.count_enable !== m_ce || bus.event_level !== m_level) begin
        errors++;
        $display("FAIL random cyc%0d ce=%b lvl=%b required %b/%b", k, bus.count_enable,
                 bus.event_level, m_ce, m_level);
      end
      if (run == 0) begin
        bus.event_in = 1'($urandom_range(1, 0));
        run = $urandom_range(12, 1);
      end
      run--;
      if ($urandom_range(63, 0) == 0) bus.mode = ~bus.mode;
      if (bus.mode == 1'b0 && $urandom_range(15, 0) == 0) bus.prescale = PW'($urandom_range(5, 0));
      if ($urandom_range(499, 0) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.count_enable !== 1'b0 || bus.event_level !== 1'b0) begin
          errors++;
          $display("FAIL random_async_reset cyc%0d ce=%b lvl=%b required 0/0", k, bus.count_enable,
                   bus.event_level);
        end
        #9 rst_n = 1'b1;
      end
    end
  endtask
  initial begin
    bus.event_in = 1'b0;
    bus.mode = 1'b0;
    bus.prescale = '0;
    test_reset();
    test_glitch();
    test_bounce();
    test_periodic();
    test_mode_switch();
    test_integration();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_pulse_gen.md
# count_pulse_gen

Front-end stage that produces the `count_enable` strobe for the 4-bit synchronous counter chain. It runs in one of two modes:
- **Event mode:** an asynchronous raw input (push-button or external event) is synchronized and debounced, and each debounced rising edge becomes a single-cycle pulse.
- **Periodic mode:** a programmable prescaler ticks once every `prescale+1` clocks.

The output drives `count_enable` of the first counter stage directly.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a level change; legal range 1..255.
- `PRESCALE_WIDTH`, default 8: width of the prescale divisor.
- `clock`  in  1: single clock, rising-edge active.
- `reset_n`  in  1: asynchronous, active-low reset; all state clears immediately on assertion.
- `event_in`  in  1: raw asynchronous event or button level.
- `mode`  in  1: 0 = event mode, 1 = periodic mode; synchronous to `clock`.
- `prescale`  in  PRESCALE_WIDTH: periodic-mode divisor; pulse period is `prescale+1` cycles.
- `count_enable`  out  1: registered single-cycle enable pulse to the counter.
- `event_level`  out  1: registered debounced level of `event_in`.

## Operation
**Reset.** While `reset_n`=0:
- sync flops = 0, `event_level` = 0, `count_enable` = 0.
- Debounce counter = 0, prescaler = 0, FSM = STABLE_LOW.

**Synchronizer.** Two flops on `event_in`; `sync` is the second flop.

**Debounce FSM.** Four states:
- STABLE_LOW: if `sync`=1, clear the counter and go to CHECK_HIGH.
- CHECK_HIGH:
  - If `sync`=0, return to STABLE_LOW and clear the counter.
  - Otherwise increment the counter. When it reaches `DEBOUNCE_CYCLES`, go to STABLE_HIGH and set `event_level` to 1.
- STABLE_HIGH: mirror of STABLE_LOW; if `sync`=0, clear the counter and go to CHECK_LOW.
- CHECK_LOW: mirror of CHECK_HIGH. On reaching the threshold, go to STABLE_LOW and clear `event_level` to 0.

**Debounce counter.** Width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.

**Event mode** (`mode`=0):
- `count_enable` is 1 for exactly one cycle following each 0→1 transition of `event_level`.
- Falling transitions produce no pulse.

**Periodic mode** (`mode`=1):
- The prescaler counts 0..`prescale`.
- When it equals `prescale`, it wraps to 0 and `count_enable` asserts on the next cycle.
- `prescale`=0 makes `count_enable` 1 on every cycle.
- If `prescale` is lowered below the current count, the prescaler wraps at its all-ones value. The next pulse may therefore be late by up to 2^PRESCALE_WIDTH cycles; this is accepted.

**Mode change.**
- On any cycle where `mode` differs from its registered copy, clear the prescaler to 0 and force `count_enable` to 0 on the following cycle.
- Debouncing continues in both modes. `event_level` is always valid.
- An `event_level` rising edge that occurs while `mode`=1 never produces a pulse later.

**Reset mid-operation.** The in-flight debounce count and any pending pulse are discarded. After reset release there is no spurious pulse, even if `event_in` is already high; the high level must still pass the full debounce.

## Timing
- **Event-mode latency.** Let edge 0 be the first rising edge that samples `event_in`=1, held high.
  - `sync`=1 after edge 1.
  - FSM in CHECK_HIGH after edge 2.
  - `event_level`=1 after edge `DEBOUNCE_CYCLES`+2.
  - `count_enable`=1 for the cycle after edge `DEBOUNCE_CYCLES`+3.
- **Glitch rejection.** A high glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no change in `event_level` and no pulse.
- **Periodic-mode start.** With `mode`=1 held from reset release, the first pulse occurs in the cycle after edge `prescale`. After that, pulses repeat every `prescale+1` cycles.
- **Pulse shape.** `count_enable` is always exactly one cycle wide, except when `prescale`=0 (continuous high). It is glitch-free because it is driven straight from a flop.

## Structure
- Shared package `count_pulse_pkg` holds:
  - the FSM state enum `{STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW}`;
  - the mode constants `MODE_EVENT=1'b0` and `MODE_PERIODIC=1'b1`.
- One sub-module, `bit_synchronizer`: a two-flop synchronizer with async active-low reset and reset value 0. It is reusable by other stages.
- The debounce FSM, prescaler and output register live in the top module.

## Test plan
- **Reset behaviour:** assert `reset_n`=0 with `event_in`=1 and `mode`=0, release, hold `event_in` high with `DEBOUNCE_CYCLES`=4 → `count_enable` is 0 throughout reset and pulses once, in the cycle after edge 7 following release.
- **Glitch rejection:** `DEBOUNCE_CYCLES`=4, pulse `event_in` high for 3 clocks → `event_level` stays 0, `count_enable` stays 0. Then hold it high for 10 clocks → exactly one pulse.
- **Bouncing input:** toggle `event_in` with the pattern 1,0,1,1,0,1,1,1,1,1 (`DEBOUNCE_CYCLES`=4) → exactly one `count_enable` pulse, after the final 4-high run. Release with a bouncing fall → no pulse.
- **Periodic mode:** `mode`=1, `prescale`=3 → pulses every 4 cycles, first in the cycle after edge 3. With `prescale`=0 → `count_enable` is continuously 1.
- **Mode switch:** switch `mode` 1→0 while the prescaler is at 2 → no pulse in the following cycle. Switch back → the first pulse comes `prescale+1` cycles later, counted from 0.
- **Integration:** drive the 4-bit counter with `mode`=1, `prescale`=0 for 16 cycles → the counter reads 0 again and its carry asserted once, when it read 15.
